// File: rtl/multi_ctrl.sv
// Multicycle CPU main control: Moore FSM sequencing fetch/decode/execute/memory/write-back,
// plus a retired-instruction counter and a sticky illegal-opcode flag.
module multi_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_r,
    output logic        mem_w,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic [31:0] instr_cnt,
    output logic        illegal
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        illegal_q, illegal_d;
    state_t      dec_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = FETCH;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs decode registered state only; during reset the FETCH selects show with strobes held low.
    assign dec_state = rst ? FETCH : state_q;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_r         = 1'b0;
        mem_w         = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        case (dec_state)
            FETCH: begin
                mem_r     = !rst;
                ir_write  = !rst;
                pc_write  = !rst;
                alu_src_b = 2'b01;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_r  = 1'b1;
                i_or_d = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_w      = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign cnt_d     = cnt_q + {31'd0, instr_done};
    assign state     = state_q;
    assign instr_cnt = cnt_q;
    assign illegal   = illegal_q;

endmodule
